pe_matrix_seq: RTL and testbench

Sequencer for the 11x11 PE matrix. Per convolution job it clears the matrix, loads the kernel (K columns through the weight bus), primes the input-feature window and scans it over the feature map in a serpentine (boustrophedon) order. It drives the matrix streaming-mode select and the feeder handshake, and tags each completed window with its output (row, col). It sits between the layer-level job controller and the PE matrix/feature feeder.

---
 rtl/pe_matrix_seq.sv | 270 +++++++++++++++++++++++++++
 tb/tb_pe_matrix_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_matrix_seq.sv
// pe_matrix_seq: per-job sequencer for the PE matrix.
// Clears the matrix, loads K weight columns, primes the input window and
// walks it over the feature map in serpentine order, tagging each completed
// window with its output (row, col) PROD_LAT cycles later.
module pe_matrix_seq #(
    parameter int DIM      = 11,
    parameter int FW       = 8,
    parameter int PROD_LAT = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic          abort,
    input  logic [3:0]    kernel_size,
    input  logic [FW-1:0] fmap_w,
    input  logic [FW-1:0] fmap_h,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          mat_rst,
    output logic          mat_rst_w,
    output logic [1:0]    sel,
    input  logic          feed_valid,
    output logic          feed_ready,
    output logic [1:0]    feed_dir,
    output logic          win_valid,
    output logic [FW-1:0] win_row,
    output logic [FW-1:0] win_col
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_LOADW = 3'd2;
    localparam logic [2:0] S_PRIME = 3'd3;
    localparam logic [2:0] S_SCAN  = 3'd4;
    localparam logic [2:0] S_STEP  = 3'd5;
    localparam logic [2:0] S_DRAIN = 3'd6;

    localparam logic [FW-1:0] ZERO_C = {FW{1'b0}};
    localparam logic [FW-1:0] ONE_C  = {{(FW-1){1'b0}}, 1'b1};

    // Where to go after a move that landed on (row, col) heading dir:
    // keep scanning, step down a row, or finish once the last row end is hit.
    function automatic logic [2:0] after_move(input logic [FW-1:0] row,
                                              input logic [FW-1:0] col,
                                              input logic          dir,
                                              input logic [FW-1:0] wk,
                                              input logic [FW-1:0] hk);
        logic [FW-1:0] end_col;
        end_col = dir ? ZERO_C : wk;
        if (col != end_col) begin
            after_move = S_SCAN;
        end else if (row == hk) begin
            after_move = S_DRAIN;
        end else begin
            after_move = S_STEP;
        end
    endfunction

    logic [2:0]    state_q, state_d;
    logic [3:0]    k_q, k_d;
    logic [FW-1:0] w_q, w_d, h_q, h_d;
    logic [FW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] row_q, row_d, col_q, col_d;
    logic          dir_q, dir_d;
    logic          err_q, err_d, done_q, done_d, abrt_q, abrt_d;
    logic [PROD_LAT-1:0] pv_q;
    logic [FW-1:0] pr_q [PROD_LAT];
    logic [FW-1:0] pc_q [PROD_LAT];

    logic [FW-1:0] ks_s, k_fw_s, wk_s, hk_s;
    logic          hs_s, win_s, pend_s, bad_s;
    logic [1:0]    dir_req_s;

    assign ks_s   = {{(FW-4){1'b0}}, kernel_size};
    assign k_fw_s = {{(FW-4){1'b0}}, k_q};
    assign wk_s   = w_q - k_fw_s;
    assign hk_s   = h_q - k_fw_s;
    assign bad_s  = (kernel_size == 4'd0) || (ks_s > FW'(DIM)) ||
                    (fmap_w < ks_s) || (fmap_h < ks_s);

    // Slice type requested from the feeder in the current state.
    always_comb begin
        dir_req_s = 2'b00;
        case (state_q)
            S_PRIME: dir_req_s = 2'b01;
            S_SCAN:  dir_req_s = dir_q ? 2'b10 : 2'b01;
            S_STEP:  dir_req_s = 2'b11;
            default: dir_req_s = 2'b00;
        endcase
    end

    assign feed_ready = ((state_q == S_PRIME) || (state_q == S_SCAN) ||
                         (state_q == S_STEP)) && !abort;
    assign feed_dir   = dir_req_s;
    assign hs_s       = feed_ready && feed_valid;
    assign sel        = hs_s ? dir_req_s : 2'b00;

    // Window tags still in flight ahead of the output stage.
    always_comb begin
        pend_s = 1'b0;
        for (int i = 0; i < PROD_LAT - 1; i++) begin
            pend_s = pend_s | pv_q[i];
        end
    end

    // Next-state, counter and window-completion logic.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        w_d     = w_q;
        h_d     = h_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        dir_d   = dir_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        abrt_d  = 1'b0;
        win_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (bad_s) begin
                        err_d = 1'b1;
                    end else begin
                        k_d     = kernel_size;
                        w_d     = fmap_w;
                        h_d     = fmap_h;
                        cnt_d   = ZERO_C;
                        row_d   = ZERO_C;
                        col_d   = ZERO_C;
                        dir_d   = 1'b0;
                        state_d = S_CLR;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLR: begin
                cnt_d   = ZERO_C;
                state_d = S_LOADW;
            end
            S_LOADW: begin
                if (cnt_q == k_fw_s - ONE_C) begin
                    cnt_d   = ZERO_C;
                    state_d = S_PRIME;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            S_PRIME: begin
                if (hs_s) begin
                    if (cnt_q == k_fw_s - ONE_C) begin
                        win_s   = 1'b1;
                        row_d   = ZERO_C;
                        col_d   = ZERO_C;
                        dir_d   = 1'b0;
                        state_d = after_move(ZERO_C, ZERO_C, 1'b0, wk_s, hk_s);
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end else begin
                    state_d = S_PRIME;
                end
            end
            S_SCAN: begin
                if (hs_s) begin
                    win_s   = 1'b1;
                    col_d   = dir_q ? (col_q - ONE_C) : (col_q + ONE_C);
                    state_d = after_move(row_q, col_d, dir_q, wk_s, hk_s);
                end else begin
                    state_d = S_SCAN;
                end
            end
            S_STEP: begin
                if (hs_s) begin
                    win_s   = 1'b1;
                    row_d   = row_q + ONE_C;
                    dir_d   = ~dir_q;
                    state_d = after_move(row_d, col_q, dir_d, wk_s, hk_s);
                end else begin
                    state_d = S_STEP;
                end
            end
            S_DRAIN: begin
                if (!pend_s) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            abrt_d  = 1'b1;
            done_d  = 1'b0;
            win_s   = 1'b0;
        end else begin
            abrt_d = 1'b0;
        end
    end

    // Control state and job registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            k_q     <= 4'd0;
            w_q     <= ZERO_C;
            h_q     <= ZERO_C;
            cnt_q   <= ZERO_C;
            row_q   <= ZERO_C;
            col_q   <= ZERO_C;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            abrt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            w_q     <= w_d;
            h_q     <= h_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            done_q  <= done_d;
            abrt_q  <= abrt_d;
        end
    end

    // Window tag delay line; an abort flushes every pending tag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pv_q <= {PROD_LAT{1'b0}};
            for (int i = 0; i < PROD_LAT; i++) begin
                pr_q[i] <= ZERO_C;
                pc_q[i] <= ZERO_C;
            end
        end else if (abrt_d) begin
            pv_q <= {PROD_LAT{1'b0}};
            for (int i = 0; i < PROD_LAT; i++) begin
                pr_q[i] <= ZERO_C;
                pc_q[i] <= ZERO_C;
            end
        end else begin
            pv_q[0] <= win_s;
            pr_q[0] <= win_s ? row_d : ZERO_C;
            pc_q[0] <= win_s ? col_d : ZERO_C;
            for (int i = 1; i < PROD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pr_q[i] <= pr_q[i-1];
                pc_q[i] <= pc_q[i-1];
            end
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign mat_rst   = (state_q == S_CLR) || abrt_q;
    assign mat_rst_w = (state_q == S_LOADW);
    assign win_valid = pv_q[PROD_LAT-1];
    assign win_row   = pr_q[PROD_LAT-1];
    assign win_col   = pc_q[PROD_LAT-1];

endmodule

// File: tb/tb_pe_matrix_seq.sv
// Testbench for pe_matrix_seq: cycle-by-cycle comparison against a queue-based
// job model, plus literal pins on the canonical K=3, W=5, H=4 job.
module tb_pe_matrix_seq;
    localparam int FW  = 8;
    localparam int LAT = 3;

    localparam int P_IDLE  = 0;
    localparam int P_CLR   = 1;
    localparam int P_LOAD  = 2;
    localparam int P_FEED  = 3;
    localparam int P_DRAIN = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          start = 1'b0, abort = 1'b0, feed_valid = 1'b0;
    logic [3:0]    kernel_size = 4'd0;
    logic [FW-1:0] fmap_w = 8'd0, fmap_h = 8'd0;
    logic          busy, done, err, mat_rst, mat_rst_w, feed_ready, win_valid;
    logic [1:0]    sel, feed_dir;
    logic [FW-1:0] win_row, win_col;

    pe_matrix_seq #(.DIM(11), .FW(FW), .PROD_LAT(LAT)) dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort),
        .kernel_size(kernel_size), .fmap_w(fmap_w), .fmap_h(fmap_h),
        .busy(busy), .done(done), .err(err), .mat_rst(mat_rst),
        .mat_rst_w(mat_rst_w), .sel(sel), .feed_valid(feed_valid),
        .feed_ready(feed_ready), .feed_dir(feed_dir), .win_valid(win_valid),
        .win_row(win_row), .win_col(win_col)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [1:0] dir; bit win; int r; int c; } mv_t;
    typedef struct { int due; int r; int c; } sc_t;

    int  vectors = 0, miscompares = 0;
    int  ph = P_IDLE, ld_left = 0, last_due = 0, cyc = 0;
    bit  m_abort = 0, m_done = 0, m_err = 0;
    mv_t mv_q[$];
    sc_t sch_q[$];

    int  n_mrst = 0, n_mrw = 0, n_done = 0, n_err = 0;
    int  obs_r[$], obs_c[$];
    int  obs_sel[$];
    int  fv_mode = 0, fv_tick = 0;

    function automatic void chk(string name, int got, int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endfunction

    // Serpentine move list: K priming slices, then one move per further window.
    function automatic void build_moves(int k, int w, int h);
        mv_t m;
        int  c;
        mv_q.delete();
        for (int i = 0; i < k; i++) begin
            m.dir = 2'b01; m.win = (i == k - 1); m.r = 0; m.c = 0;
            mv_q.push_back(m);
        end
        c = 0;
        for (int r = 0; r <= h - k; r++) begin
            if (r > 0) begin
                m.dir = 2'b11; m.win = 1; m.r = r; m.c = c;
                mv_q.push_back(m);
            end
            if (r % 2 == 0) begin
                for (int x = 1; x <= w - k; x++) begin
                    m.dir = 2'b01; m.win = 1; m.r = r; m.c = x;
                    mv_q.push_back(m);
                end
                c = w - k;
            end else begin
                for (int x = w - k - 1; x >= 0; x--) begin
                    m.dir = 2'b10; m.win = 1; m.r = r; m.c = x;
                    mv_q.push_back(m);
                end
                c = 0;
            end
        end
    endfunction

    logic [10:0] got_v, exp_v;
    logic [1:0]  e_fd, e_sel;
    bit          e_fr, hs, e_wv;
    int          old_ph;
    mv_t         mm;
    sc_t         ss;

    // Per-cycle model step and output comparison.
    always @(negedge CLK) begin
        got_v = {busy, done, err, mat_rst, mat_rst_w, sel, feed_ready, feed_dir, win_valid};
        if (!RST) begin
            ph = P_IDLE; mv_q.delete(); sch_q.delete();
            m_abort = 0; m_done = 0; m_err = 0;
            chk("reset_outs", int'({got_v, win_row, win_col}), 0);
        end else begin
            e_fr = (ph == P_FEED) && !abort;
            e_fd = 2'b00;
            if (ph == P_FEED) e_fd = mv_q[0].dir;
            hs    = e_fr && feed_valid;
            e_sel = hs ? e_fd : 2'b00;
            e_wv  = (sch_q.size() > 0) && (sch_q[0].due == cyc);
            exp_v = {ph != P_IDLE, m_done, m_err, (ph == P_CLR) || m_abort,
                     ph == P_LOAD, e_sel, e_fr, e_fd, e_wv};
            chk("outs", int'(got_v), int'(exp_v));
            if (e_wv && win_valid)
                chk("tag", int'({win_row, win_col}), sch_q[0].r * 256 + sch_q[0].c);
            if (mat_rst)   n_mrst++;
            if (mat_rst_w) n_mrw++;
            if (done)      n_done++;
            if (err)       n_err++;
            if (win_valid) begin obs_r.push_back(win_row); obs_c.push_back(win_col); end
            if (sel != 2'b00) obs_sel.push_back(sel);

            old_ph = ph; m_abort = 0; m_done = 0; m_err = 0;
            if (e_wv) void'(sch_q.pop_front());
            case (ph)
                P_IDLE: if (start && !abort) begin
                    if (kernel_size >= 1 && kernel_size <= 11 &&
                        fmap_w >= kernel_size && fmap_h >= kernel_size) begin
                        build_moves(kernel_size, fmap_w, fmap_h);
                        ld_left = kernel_size;
                        ph = P_CLR;
                    end else m_err = 1;
                end
                P_CLR:  ph = P_LOAD;
                P_LOAD: begin ld_left--; if (ld_left == 0) ph = P_FEED; end
                P_FEED: if (hs) begin
                    mm = mv_q.pop_front();
                    if (mm.win) begin
                        ss.due = cyc + LAT; ss.r = mm.r; ss.c = mm.c;
                        sch_q.push_back(ss); last_due = ss.due;
                    end
                    if (mv_q.size() == 0) ph = P_DRAIN;
                end
                P_DRAIN: if (cyc == last_due) begin ph = P_IDLE; m_done = 1; end
                default: ph = P_IDLE;
            endcase
            if (abort && old_ph != P_IDLE) begin
                ph = P_IDLE; m_abort = 1; m_done = 0; sch_q.delete(); mv_q.delete();
            end
            cyc++;
        end
    end

    // Feeder valid pattern generator.
    initial begin
        forever begin
            @(posedge CLK); #1;
            fv_tick++;
            case (fv_mode)
                0:       feed_valid = 1'b1;
                1:       feed_valid = fv_tick[0];
                default: feed_valid = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic clear_obs();
        n_mrst = 0; n_mrw = 0; n_done = 0; n_err = 0;
        obs_r.delete(); obs_c.delete(); obs_sel.delete();
    endtask

    task automatic do_start(int k, int w, int h);
        @(posedge CLK); #1;
        kernel_size = k[3:0]; fmap_w = w[7:0]; fmap_h = h[7:0]; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(string name, int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge CLK);
            if (done) seen = 1;
        end
        chk(name, int'(seen), 1);
        @(negedge CLK);
    endtask

    task automatic wait_sel(int n, int budget);
        for (int i = 0; i < budget && obs_sel.size() < n; i++) @(negedge CLK);
        chk("sel_progress", int'(obs_sel.size() >= n), 1);
    endtask

    task automatic check_k3_tags(string name);
        int er[6] = '{0, 0, 0, 1, 1, 1};
        int ec[6] = '{0, 1, 2, 2, 1, 0};
        int es[8] = '{1, 1, 1, 1, 1, 3, 2, 2};
        chk({name, "_ntags"}, obs_r.size(), 6);
        for (int i = 0; i < 6 && i < obs_r.size(); i++)
            chk({name, "_tag"}, obs_r[i] * 256 + obs_c[i], er[i] * 256 + ec[i]);
        chk({name, "_nsel"}, obs_sel.size(), 8);
        for (int i = 0; i < 8 && i < obs_sel.size(); i++)
            chk({name, "_sel"}, obs_sel[i], es[i]);
        chk({name, "_mrst"}, n_mrst, 1);
        chk({name, "_mrw"}, n_mrw, 3);
        chk({name, "_done"}, n_done, 1);
    endtask

    initial begin
        int er[6] = '{0, 0, 0, 1, 1, 1};
        int ec[6] = '{0, 1, 2, 2, 1, 0};
        int idx, k, w, h;

        // Pin the model's serpentine order for the canonical job.
        build_moves(3, 5, 4);
        chk("model_nmoves", mv_q.size(), 8);
        idx = 0;
        foreach (mv_q[i]) if (mv_q[i].win) begin
            if (idx < 6) chk("model_tag", mv_q[i].r * 256 + mv_q[i].c, er[idx] * 256 + ec[idx]);
            idx++;
        end
        chk("model_nwin", idx, 6);
        mv_q.delete();

        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        repeat (2) @(posedge CLK);

        // Canonical job, feeder always ready.
        fv_mode = 0; clear_obs();
        do_start(3, 5, 4); wait_done("t1_done", 300);
        check_k3_tags("t1");

        // Same job with a stalling feeder.
        fv_mode = 1; clear_obs();
        do_start(3, 5, 4); wait_done("t2_done", 300);
        check_k3_tags("t2");

        // Maximum kernel: one window only.
        fv_mode = 0; clear_obs();
        do_start(11, 11, 11); wait_done("t3_done", 300);
        chk("t3_mrw", n_mrw, 11);
        chk("t3_nsel", obs_sel.size(), 11);
        chk("t3_ntags", obs_r.size(), 1);

        // Rejected starts.
        clear_obs();
        do_start(12, 20, 20); repeat (3) @(negedge CLK);
        do_start(3, 2, 5);    repeat (3) @(negedge CLK);
        chk("t4_err", n_err, 2);
        chk("t4_mrst", n_mrst, 0);

        // Abort early in the scan, then a clean job.
        fv_mode = 0; clear_obs();
        do_start(3, 5, 4); wait_sel(4, 100);
        @(posedge CLK); #1 abort = 1'b1;
        @(posedge CLK); #1 abort = 1'b0;
        repeat (12) @(negedge CLK);
        chk("t5_done", n_done, 0);
        chk("t5_mrst", n_mrst, 2);
        clear_obs();
        do_start(3, 5, 4); wait_done("t5b_done", 300);
        check_k3_tags("t5b");

        // Reset mid-scan; no stale window afterwards.
        fv_mode = 2; clear_obs();
        do_start(3, 5, 4); wait_sel(5, 200);
        @(posedge CLK); #1 RST = 1'b0;
        repeat (2) @(posedge CLK); #1 RST = 1'b1;
        clear_obs();
        repeat (10) @(negedge CLK);
        chk("t6_stale", obs_r.size(), 0);
        fv_mode = 0;
        do_start(3, 5, 4); wait_done("t6b_done", 300);
        check_k3_tags("t6b");

        // Randomized jobs with a random feeder and ignored mid-job starts.
        fv_mode = 2;
        for (int j = 0; j < 10; j++) begin
            k = $urandom_range(1, 5);
            w = k + $urandom_range(0, 4);
            h = k + $urandom_range(0, 3);
            if (j % 4 == 3) w = k - 1;
            do_start(k, w, h);
            if (w >= k && k >= 1) begin
                @(posedge CLK); #1;
                kernel_size = 4'd2; fmap_w = 8'd9; fmap_h = 8'd9; start = 1'b1;
                @(posedge CLK); #1 start = 1'b0;
                wait_done("rnd_done", 2000);
            end else begin
                repeat (3) @(negedge CLK);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end
endmodule
